uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl_if.sv | 37 +++
 rtl/uart_tx_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: bundles the producer-side request signals and the
// serial-line / status outputs of the UART TX frame sequencer.
// The master side is the byte producer; the slave side is the sequencer.

interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_En;
    logic                  Par_Type;
    logic                  TX_OUT;
    logic                  busy;
    logic                  tx_done;

    modport master (
        output P_DATA,
        output Data_Valid,
        output Par_En,
        output Par_Type,
        input  TX_OUT,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  Par_En,
        input  Par_Type,
        output TX_OUT,
        output busy,
        output tx_done
    );

endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer, one bit per TX clock.
// Frame = start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// TX_OUT, busy and tx_done are registered: the combinational block computes
// the value each output must carry in the *next* state, and the output flops
// load it on the same edge as the state register, so the flops always agree
// with the state they describe.

module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_ctrl_if.slave     bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity of the captured word; odd parity is its inverse.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  par_q,      par_d;
    logic                  tx_out_q,   tx_out_d;
    logic                  busy_q,     busy_d;
    logic                  tx_done_q,  tx_done_d;

    // Next-state and next-output decode; every target defaults to hold/idle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_d      = par_q;
        tx_out_d   = 1'b1;
        busy_d     = 1'b0;
        tx_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Data_Valid) begin
                    // Capture the word and its configuration; the frame in
                    // flight never looks at the bus inputs again.
                    state_d    = START;
                    shift_d    = bus.P_DATA;
                    cnt_d      = CNT_ZERO;
                    par_en_d   = bus.Par_En;
                    par_type_d = bus.Par_Type;
                    par_d      = even_parity(bus.P_DATA);
                    tx_out_d   = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = IDLE;
                end
            end

            START: begin
                // Put bit 0 on the line next and pre-shift for bit 1.
                state_d  = DATA;
                tx_out_d = shift_q[0];
                shift_d  = {1'b0, shift_q[DATA_WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_ONE;
                busy_d   = 1'b1;
            end

            DATA: begin
                // cnt_q counts bits already placed on the line.
                if (cnt_q == CNT_LAST) begin
                    if (par_en_q) begin
                        state_d  = PARITY;
                        tx_out_d = par_q ^ par_type_q;
                    end else begin
                        state_d  = STOP;
                        tx_out_d = 1'b1;
                    end
                end else begin
                    state_d  = DATA;
                    tx_out_d = shift_q[0];
                    shift_d  = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    cnt_d    = cnt_q + CNT_ONE;
                end
                busy_d = 1'b1;
            end

            PARITY: begin
                state_d  = STOP;
                tx_out_d = 1'b1;
                busy_d   = 1'b1;
            end

            STOP: begin
                // The following IDLE cycle carries the tx_done pulse.
                state_d   = IDLE;
                tx_out_d  = 1'b1;
                busy_d    = 1'b0;
                tx_done_d = 1'b1;
            end

            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= {DATA_WIDTH{1'b0}};
            cnt_q      <= CNT_ZERO;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_q      <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_q      <= par_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign bus.TX_OUT  = tx_out_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed frame vectors for the UART TX frame sequencer.
// Each vector lists, per cycle after the accept edge, the expected TX_OUT,
// busy and tx_done as '0'/'1' strings written out by hand.

module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    logic rst;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       pe;
        logic       pt;
        string      line;
        string      bsy;
        string      dn;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic ch(input string s, input int i);
        return (s[i] == 8'h31);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string nm, input int i,
                               input logic et, input logic eb, input logic ed);
        n_vec++;
        if (bus.TX_OUT !== et || bus.busy !== eb || bus.tx_done !== ed) begin
            n_err++;
            $display("FAIL %s cycle %0d: got tx=%b busy=%b done=%b, want tx=%b busy=%b done=%b",
                     nm, i, bus.TX_OUT, bus.busy, bus.tx_done, et, eb, ed);
        end
    endtask

    task automatic add_vec(input string nm, input logic [7:0] d, input logic pe,
                           input logic pt, input string ln, input string bs,
                           input string dn);
        vec_t v;
        v.name = nm; v.data = d; v.pe = pe; v.pt = pt;
        v.line = ln; v.bsy = bs; v.dn = dn;
        vq.push_back(v);
    endtask

    // One-cycle Data_Valid, then 12 checked cycles (frame plus trailing idle).
    task automatic run_vec(input vec_t v);
        bus.P_DATA     = v.data;
        bus.Par_En     = v.pe;
        bus.Par_Type   = v.pt;
        bus.Data_Valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_cycle(v.name, i, ch(v.line, i), ch(v.bsy, i), ch(v.dn, i));
            bus.Data_Valid = 1'b0;
        end
    endtask

    initial begin
        //        name        data   pe    pt    TX_OUT          busy            tx_done
        add_vec("a5_even", 8'hA5, 1'b1, 1'b0, "010100101011", "111111111110", "000000000001");
        add_vec("01_odd",  8'h01, 1'b1, 1'b1, "010000000011", "111111111110", "000000000001");
        add_vec("01_nopar",8'h01, 1'b0, 1'b1, "010000000111", "111111111100", "000000000010");
        add_vec("a5_odd",  8'hA5, 1'b1, 1'b1, "010100101111", "111111111110", "000000000001");
        add_vec("ff_even", 8'hFF, 1'b1, 1'b0, "011111111011", "111111111110", "000000000001");
        add_vec("00_odd",  8'h00, 1'b1, 1'b1, "000000000111", "111111111110", "000000000001");
        add_vec("c3_nopar",8'hC3, 1'b0, 1'b0, "011000011111", "111111111100", "000000000010");

        // Reset with random inputs, including Data_Valid=1: reset wins.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.P_DATA     = 8'($urandom);
            bus.Par_En     = 1'($urandom);
            bus.Par_Type   = 1'($urandom);
            bus.Data_Valid = 1'b1;
            tick();
            check_cycle("reset", i, 1'b1, 1'b0, 1'b0);
        end
        rst            = 1'b0;
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_cycle("post_reset", i, 1'b1, 1'b0, 1'b0);
        end

        // Table-driven frames.
        for (int k = 0; k < vq.size(); k++) begin
            run_vec(vq[k]);
        end

        // Busy protection: 8'h3C even parity while inputs churn mid-frame.
        bus.P_DATA     = 8'h3C;
        bus.Par_En     = 1'b1;
        bus.Par_Type   = 1'b0;
        bus.Data_Valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_cycle("busy_prot", i, ch("000111100011", i),
                        ch("111111111110", i), ch("000000000001", i));
            if (i < 9) begin
                bus.P_DATA     = 8'hFF;
                bus.Par_En     = ~bus.Par_En;
                bus.Par_Type   = ~bus.Par_Type;
                bus.Data_Valid = (i % 2 == 0);
            end else begin
                bus.Data_Valid = 1'b0;
            end
        end
        tick();
        check_cycle("busy_prot_no2nd", 12, 1'b1, 1'b0, 1'b0);

        // Back-to-back: Data_Valid held, 8'h55 then 8'hAA, no parity.
        bus.P_DATA     = 8'h55;
        bus.Par_En     = 1'b0;
        bus.Par_Type   = 1'b0;
        bus.Data_Valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            check_cycle("b2b", i, ch("0101010101100101010111", i),
                        ch("1111111111011111111110", i),
                        ch("0000000000100000000001", i));
            if (i == 0)  bus.P_DATA     = 8'hAA;
            if (i == 11) bus.Data_Valid = 1'b0;
        end

        // Mid-frame reset during data bit 4, then a clean frame.
        bus.P_DATA     = 8'hA5;
        bus.Par_En     = 1'b1;
        bus.Par_Type   = 1'b0;
        bus.Data_Valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_cycle("mid_rst_pre", i, ch("010100101011", i),
                        ch("111111111110", i), ch("000000000001", i));
            bus.Data_Valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        check_cycle("mid_rst", 0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_cycle("mid_rst_after", 1, 1'b1, 1'b0, 1'b0);
        run_vec(vq[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
